if_fetch_unit: RTL and testbench
================================

Name: if_fetch_unit

Overview:
Instruction-fetch front end of open_risc_v. Owns the PC, drives the synchronous instruction ROM address and aligns the returned word with its PC. Presents {inst, inst_addr, valid} to the if_id register; honours ctrl hold and ex-stage jump redirects. Sits directly upstream of the fetch path the SoC bench loads via the ROM.

Parameters:
PC_RESET, 32'h0000_0000, PC value loaded on reset
ROM_AW, 12, ROM word-address width (4096 words)
INST_NOP, 32'h0000_0013, bubble instruction (addi x0,x0,0)

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  asynchronous active-low reset (0 = reset)
jump_en_i  in  1  redirect request from ex
jump_addr_i  in  32  redirect target, byte address
hold_flag_i  in  1  ctrl stall; fetch outputs must stay stable
rom_addr_o  out  ROM_AW  ROM word address = pc_r[ROM_AW+1:2]
rom_rdata_i  in  32  ROM data, valid one cycle after rom_addr_o
inst_o  out  32  instruction to if_id
inst_addr_o  out  32  byte PC of inst_o
inst_valid_o  out  1  inst_o is a real fetched instruction

Behaviour:
- Interface: one clock (clk); reset rst is asynchronous, active-low.
- State: pc_r[31:0], req_pc_r[31:0], req_vld_r, held_r, buf_inst[31:0], buf_addr[31:0], buf_vld.
- Reset (async, immediate): pc_r=PC_RESET, req_pc_r=PC_RESET, req_vld_r=0, held_r=0, buf_*=0. Outputs: inst_o=INST_NOP, inst_addr_o=PC_RESET, inst_valid_o=0, rom_addr_o=PC_RESET[ROM_AW+1:2].
- Live outputs: inst=req_vld_r ? rom_rdata_i : INST_NOP; addr=req_pc_r; valid=req_vld_r.
- Final outputs: held_r ? buf_* : live. When buf_vld=0, inst_o=INST_NOP.
- Each cycle, priority jump > hold > run:
  - Jump (jump_en_i=1): pc_r<=jump_addr_i with bits[1:0] forced 0; req_vld_r<=0; held_r<=0. The cycle after the jump outputs NOP/valid=0. The target instruction appears 2 cycles after the jump cycle. Jump overrides an active hold.
  - Hold (hold_flag_i=1, no jump): pc_r, req_pc_r and req_vld_r frozen. If held_r=0, capture the live outputs into buf_* and set held_r<=1. Outputs remain bit-identical through the whole hold.
  - Run: pc_r<=pc_r+4; req_pc_r<=pc_r; req_vld_r<=1; held_r<=0. On the first run cycle after a hold, outputs still come from the buffer. The next cycle shows mem[pc_r] for the frozen pc_r, so no instruction is lost or duplicated.
- Latency: ROM word at address A appears on inst_o exactly one cycle after rom_addr_o=A in a run cycle.
- First valid instruction: the cycle after the first run edge following rst release; inst_addr_o=PC_RESET.
- PC arithmetic is mod 2^32: 32'hFFFF_FFFC+4 wraps to 0. rom_addr_o truncates the PC, so the ROM aliases.
- Reset asserted mid-hold or mid-jump: all state cleared asynchronously; the buffer is discarded.

Decomposition:
- Shared package rv_defines: INST_NOP, XLEN=32, ROM_AW default, PC_RESET.
- One sub-module, fetch_hold_buf: the 65-bit capture register plus output mux (inputs live bundle, hold, jump; outputs final bundle, held_r).
- PC/request logic stays in if_fetch_unit.

Test Plan:
- Reset release, ROM[0..3]=0x00100093,0x00200113,0x00300193,0x00400213 -> inst_valid_o=0 during reset; then inst_o sequence 0x00100093@0, 0x00200113@4, 0x00300193@8, one per cycle.
- Hold 3 cycles while inst_addr_o=4 -> inst_o=0x00200113 and addr=4 constant for the hold cycles plus the release cycle; then addr=8, no skip or duplicate.
- jump_en_i=1, jump_addr_i=0x40 while outputs at addr 8 -> next cycle NOP/valid=0; following cycle inst_o=ROM[16], inst_addr_o=0x40.
- Jump asserted during an active hold, target 0x102 -> hold ignored; bubble; then inst_addr_o=0x100.
- rst pulsed low mid-run (not on a clock edge) -> outputs NOP/valid=0 immediately, PC_RESET restarts fetch.
- Jump to 0xFFFF_FFFC, run 2 cycles -> inst_addr_o 0xFFFF_FFFC then 0x0000_0000.

Source files
------------

// File: rtl/if_fetch_unit_pkg.sv
// Purpose: shared fetch-path constants and the packed fetch output bundle.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package rv_defines;

  localparam int              XLEN        = 32;
  localparam int              RV_ROM_AW   = 12;
  localparam logic [XLEN-1:0] RV_PC_RESET = 32'h0000_0000;
  localparam logic [XLEN-1:0] RV_INST_NOP = 32'h0000_0013;  // addi x0,x0,0

  // What fetch hands to if_id: 65 bits, captured whole while stalled.
  typedef struct packed {
    logic [XLEN-1:0] inst;
    logic [XLEN-1:0] addr;
    logic            vld;
  } fetch_bundle_t;

endpackage

// File: rtl/if_fetch_unit_if.sv
// Purpose: fetch-unit bus, covering ex redirect, ctrl hold, ROM port and the if_id-facing bundle.
// Latency: n/a (wiring only).
// Backpressure: hold_flag_i freezes the fetch outputs; there is no ready signal.
interface if_fetch_unit_if #(
  parameter int ROM_AW = 12
) ();
  logic              jump_en_i;
  logic [31:0]       jump_addr_i;
  logic              hold_flag_i;
  logic [ROM_AW-1:0] rom_addr_o;
  logic [31:0]       rom_rdata_i;
  logic [31:0]       inst_o;
  logic [31:0]       inst_addr_o;
  logic              inst_valid_o;

  // Fetch unit side.
  modport master (
    input  jump_en_i, jump_addr_i, hold_flag_i, rom_rdata_i,
    output rom_addr_o, inst_o, inst_addr_o, inst_valid_o
  );

  // Environment side: ex/ctrl, ROM and if_id.
  modport slave (
    output jump_en_i, jump_addr_i, hold_flag_i, rom_rdata_i,
    input  rom_addr_o, inst_o, inst_addr_o, inst_valid_o
  );
endinterface

// File: rtl/if_fetch_unit_hold_buf.sv
// Purpose: freezes the fetch bundle during a ctrl hold and muxes it onto the outputs.
// Latency: live bundle passes through combinationally; the frozen copy is shown from the cycle after capture.
// Backpressure: the first held edge captures; the copy is shown until a run or jump edge releases it.
module fetch_hold_buf
  import rv_defines::*;
#(
  parameter logic [XLEN-1:0] INST_NOP = RV_INST_NOP
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          hold,
  input  logic          jump,
  input  fetch_bundle_t live,
  output fetch_bundle_t final_b
);

  logic          held_r;
  fetch_bundle_t buf_r;

  // Capture on the first held edge only; a jump or a run edge drops the hold.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      held_r <= 1'b0;
      buf_r  <= '0;
    end else if (jump) begin
      held_r <= 1'b0;
    end else if (hold) begin
      if (!held_r) begin
        buf_r  <= live;
        held_r <= 1'b1;
      end
    end else begin
      held_r <= 1'b0;
    end
  end

  // While held, show the frozen copy; an invalid copy always reads as a bubble.
  always_comb begin
    final_b = live;
    if (held_r) begin
      final_b = buf_r;
      if (!buf_r.vld) final_b.inst = INST_NOP;
    end
  end

endmodule

// File: rtl/if_fetch_unit.sv
// Purpose: instruction fetch. Owns the PC, drives the sync ROM address and pairs the returned word with its PC.
// Latency: the ROM word at rom_addr_o appears on inst_o one cycle after a run edge; jump target appears 2 cycles after the jump.
// Backpressure: hold_flag_i freezes the PC and keeps the outputs bit-identical; jump_en_i overrides hold.
module if_fetch_unit
  import rv_defines::*;
#(
  parameter logic [XLEN-1:0] PC_RESET = RV_PC_RESET,
  parameter int              ROM_AW   = RV_ROM_AW,
  parameter logic [XLEN-1:0] INST_NOP = RV_INST_NOP
) (
  input logic             clk,
  input logic             rst,
  if_fetch_unit_if.master bus
);

  logic [XLEN-1:0] pc_r;       // address currently on the ROM port
  logic [XLEN-1:0] req_pc_r;   // address whose data is on rom_rdata_i now
  logic            req_vld_r;  // rom_rdata_i holds a real instruction
  fetch_bundle_t   live;
  fetch_bundle_t   final_b;

  // PC and request tracking: jump beats hold beats run.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_r      <= PC_RESET;
      req_pc_r  <= PC_RESET;
      req_vld_r <= 1'b0;
    end else if (bus.jump_en_i) begin
      pc_r      <= bus.jump_addr_i & ~32'h3;
      req_vld_r <= 1'b0;
    end else if (!bus.hold_flag_i) begin
      pc_r      <= pc_r + 32'd4;
      req_pc_r  <= pc_r;
      req_vld_r <= 1'b1;
    end
  end

  // Pair the ROM data with the PC that requested it.
  always_comb begin
    live.inst = req_vld_r ? bus.rom_rdata_i : INST_NOP;
    live.addr = req_pc_r;
    live.vld  = req_vld_r;
  end

  fetch_hold_buf #(
    .INST_NOP (INST_NOP)
  ) u_hold_buf (
    .clk     (clk),
    .rst     (rst),
    .hold    (bus.hold_flag_i),
    .jump    (bus.jump_en_i),
    .live    (live),
    .final_b (final_b)
  );

  // The ROM sees a word address and aliases above ROM_AW.
  assign bus.rom_addr_o   = pc_r[ROM_AW+1:2];
  assign bus.inst_o       = final_b.inst;
  assign bus.inst_addr_o  = final_b.addr;
  assign bus.inst_valid_o = final_b.vld;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Purpose: self-checking bench for if_fetch_unit with a directed vector table, async reset sequences and randomized traffic.
// Latency: expects data one cycle after the run edge and a 2-cycle jump-to-target delay.
// Backpressure: drives hold_flag_i and jump_en_i and checks that outputs are frozen or redirected.
module tb_if_fetch_unit;
  import rv_defines::*;

  localparam int          AW  = 12;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  if_fetch_unit_if #(.ROM_AW(AW)) bus ();

  if_fetch_unit #(
    .PC_RESET (32'h0000_0000),
    .ROM_AW   (AW),
    .INST_NOP (NOP)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Synchronous instruction ROM.
  logic [31:0] mem [4096];
  always @(posedge clk) bus.rom_rdata_i <= mem[bus.rom_addr_o];

  int n_cmp;
  int n_err;

  // Reference model: the instruction stream as seen by if_id.
  // m_npc is the next instruction address to hand out; run emits it, hold repeats, jump emits a bubble.
  logic [31:0] m_npc, m_inst, m_addr;
  logic        m_vld;

  function automatic logic [31:0] rom_word(input logic [31:0] byte_addr);
    return mem[int'((byte_addr >> 2) % 4096)];
  endfunction

  task automatic model_reset();
    m_npc  = 32'h0;
    m_inst = NOP;
    m_addr = 32'h0;
    m_vld  = 1'b0;
  endtask

  task automatic model_step(input logic j, input logic [31:0] ja, input logic h);
    if (j) begin
      m_inst = NOP;
      m_vld  = 1'b0;
      m_npc  = ja & ~32'h3;
    end else if (!h) begin
      m_inst = rom_word(m_npc);
      m_addr = m_npc;
      m_vld  = 1'b1;
      m_npc  = m_npc + 32'd4;
    end
  endtask

  // Called at a negedge: drive inputs for one cycle, advance the model at the edge, return at the next negedge.
  task automatic cyc(input logic j, input logic [31:0] ja, input logic h);
    bus.jump_en_i   = j;
    bus.jump_addr_i = ja;
    bus.hold_flag_i = h;
    @(posedge clk);
    model_step(j, ja, h);
    @(negedge clk);
  endtask

  task automatic chk(input string nm, input logic [31:0] ei, input logic [31:0] ea,
                     input logic ev, input logic use_addr);
    n_cmp++;
    if (bus.inst_o !== ei || bus.inst_valid_o !== ev || (use_addr && bus.inst_addr_o !== ea)) begin
      n_err++;
      $display("FAIL %s: got inst=%h addr=%h vld=%b, want inst=%h addr=%h vld=%b",
               nm, bus.inst_o, bus.inst_addr_o, bus.inst_valid_o, ei, ea, ev);
    end
  endtask

  task automatic chk_rom(input string nm, input logic [AW-1:0] ea);
    n_cmp++;
    if (bus.rom_addr_o !== ea) begin
      n_err++;
      $display("FAIL %s: got rom_addr=%h, want %h", nm, bus.rom_addr_o, ea);
    end
  endtask

  typedef struct {
    logic        j;
    logic [31:0] ja;
    logic        h;
    logic [31:0] ei;
    logic [31:0] ea;
    logic        ev;
    string       nm;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic j, input logic [31:0] ja, input logic h,
                     input logic [31:0] ei, input logic [31:0] ea, input logic ev, input string nm);
    vec_t v;
    v.j = j; v.ja = ja; v.h = h; v.ei = ei; v.ea = ea; v.ev = ev; v.nm = nm;
    tbl.push_back(v);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    for (int i = 0; i < 4096; i++) mem[i] = 32'hA000_0000 + i;
    mem[0] = 32'h0010_0093;
    mem[1] = 32'h0020_0113;
    mem[2] = 32'h0030_0193;
    mem[3] = 32'h0040_0213;

    bus.jump_en_i   = 1'b0;
    bus.jump_addr_i = 32'h0;
    bus.hold_flag_i = 1'b0;
    rst = 1'b0;
    model_reset();

    // Reset state.
    repeat (3) @(negedge clk);
    chk("reset_out", NOP, 32'h0, 1'b0, 1'b1);
    chk_rom("reset_rom", '0);
    rst = 1'b1;

    // Directed vectors: inputs for one cycle, then the outputs expected in the next cycle.
    add(0, 0,            0, 32'h0010_0093, 32'h0000_0000, 1, "first_inst");
    add(0, 0,            0, 32'h0020_0113, 32'h0000_0004, 1, "seq_4");
    add(0, 0,            1, 32'h0020_0113, 32'h0000_0004, 1, "hold_1");
    add(0, 0,            1, 32'h0020_0113, 32'h0000_0004, 1, "hold_2");
    add(0, 0,            1, 32'h0020_0113, 32'h0000_0004, 1, "hold_release");
    add(0, 0,            0, 32'h0030_0193, 32'h0000_0008, 1, "after_hold_8");
    add(1, 32'h40,       0, NOP,           32'h0,         0, "jump_bubble");
    add(0, 0,            0, 32'hA000_0010, 32'h0000_0040, 1, "jump_target");
    add(0, 0,            0, 32'hA000_0011, 32'h0000_0044, 1, "jump_next");
    add(0, 0,            1, 32'hA000_0011, 32'h0000_0044, 1, "hold_pre_jump");
    add(1, 32'h102,      1, NOP,           32'h0,         0, "jump_in_hold");
    add(0, 0,            0, 32'hA000_0040, 32'h0000_0100, 1, "jump_in_hold_tgt");
    add(1, 32'hFFFF_FFFC,0, NOP,           32'h0,         0, "jump_top_bubble");
    add(0, 0,            0, 32'hA000_0FFF, 32'hFFFF_FFFC, 1, "pc_top");
    add(0, 0,            0, 32'h0010_0093, 32'h0000_0000, 1, "pc_wrap");
    add(0, 0,            0, 32'h0020_0113, 32'h0000_0004, 1, "pc_wrap_next");
    add(1, 32'h8,        0, NOP,           32'h0,         0, "jump8_bubble");
    add(0, 0,            1, NOP,           32'h0,         0, "hold_bubble");
    add(0, 0,            0, 32'h0030_0193, 32'h0000_0008, 1, "hold_bubble_rel");

    foreach (tbl[k]) begin
      cyc(tbl[k].j, tbl[k].ja, tbl[k].h);
      chk(tbl[k].nm, tbl[k].ei, tbl[k].ea, tbl[k].ev, tbl[k].ev);
    end

    // Async reset mid-hold: outputs drop immediately, the buffer is discarded.
    cyc(0, 0, 0);
    chk("pre_rst_run", m_inst, m_addr, m_vld, m_vld);
    cyc(0, 0, 1);
    cyc(0, 0, 1);
    chk("pre_rst_hold", m_inst, m_addr, m_vld, m_vld);
    #2 rst = 1'b0;
    #1;
    chk("async_rst_out", NOP, 32'h0, 1'b0, 1'b1);
    chk_rom("async_rst_rom", '0);
    @(negedge clk);
    bus.hold_flag_i = 1'b0;
    rst = 1'b1;
    model_reset();
    cyc(0, 0, 0);
    chk("restart_0", 32'h0010_0093, 32'h0, 1'b1, 1'b1);
    cyc(0, 0, 0);
    chk("restart_4", 32'h0020_0113, 32'h4, 1'b1, 1'b1);

    // Random traffic against the stream model.
    for (int n = 0; n < 600; n++) begin
      logic        j, h;
      logic [31:0] ja;
      j  = ($urandom % 10) == 0;
      h  = ($urandom % 4) == 0;
      ja = (($urandom % 5) == 0) ? $urandom : ($urandom & 32'h0000_3FFF);
      cyc(j, ja, h);
      chk("rand_out", m_inst, m_addr, m_vld, m_vld);
      chk_rom("rand_rom", AW'((m_npc >> 2) % 4096));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
